// File: rtl/if_fetch_ctrl_if.sv
// Instruction-memory request/acknowledge bus.
//   req  : fetch request, driven by the fetch controller
//   addr : fetch address, stable from req until the ack cycle
//   ack  : fetch complete; data valid in this cycle
//   data : fetched instruction word
// master = fetch controller side, slave = instruction memory side.
interface if_fetch_ctrl_if;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] data;

  modport master (output req, addr, input ack, data);
  modport slave  (input req, addr, output ack, data);
endinterface

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch stage controller. Owns the PC and the IF/ID pipeline
// register, issues fetches on a variable-latency req/ack memory bus and
// applies stall / flush / redirect controls coming from the hazard unit.
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   start_i               leave IDLE and begin fetching
//   stall_i, flush_i,
//   pc_hazard_i           hazard unit controls (flush 01 flush, 10 new, 00/11 hold)
//   jump_i/jump_target_i, branch_taken_i/branch_target_i
//                         redirect requests resolved in ID (used on flush 01)
//   imem                  instruction memory bus (master side)
//   if_id_inst_o, if_id_pc4_o, if_id_valid_o
//                         registered IF/ID contents
//   fetch_busy_o          fetch outstanding without ack, or discarding
module if_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic                   stall_i,
  input  logic [1:0]             flush_i,
  input  logic                   pc_hazard_i,
  input  logic                   jump_i,
  input  logic [31:0]            jump_target_i,
  input  logic                   branch_taken_i,
  input  logic [31:0]            branch_target_i,
  if_fetch_ctrl_if.master        imem,
  output logic [31:0]            if_id_inst_o,
  output logic [31:0]            if_id_pc4_o,
  output logic                   if_id_valid_o,
  output logic                   fetch_busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_DISCARD = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] saved_target_q, saved_target_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;

  logic        hold;
  logic        redirect;
  logic        new_inst;
  logic [31:0] pc_plus4;
  logic [31:0] target;

  // Codes 00 and 11 both mean "hold"; any hold source overrides 01/10.
  assign hold     = stall_i | pc_hazard_i | (flush_i[1] == flush_i[0]);
  assign redirect = ~hold & (flush_i == 2'b01);
  assign new_inst = ~hold & (flush_i == 2'b10);
  assign pc_plus4 = pc_q + 32'd4;
  assign target   = jump_i         ? jump_target_i   :
                    branch_taken_i ? branch_target_i : pc_plus4;

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    saved_target_d = saved_target_q;
    inst_d         = inst_q;
    pc4_d          = pc4_q;
    valid_d        = valid_q;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_FETCH;
        end
      end

      ST_FETCH: begin
        if (imem.ack) begin
          if (redirect) begin
            inst_d  = NOP_INST;
            pc4_d   = pc_plus4;
            valid_d = 1'b0;
            pc_d    = target;
          end else if (new_inst) begin
            inst_d  = imem.data;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
            pc_d    = pc_plus4;
          end
        end else begin
          // Fetch still outstanding: ID must not see a stale instruction.
          if (redirect || new_inst) begin
            inst_d  = NOP_INST;
            valid_d = 1'b0;
          end
          // The address may not move until ack, so remember where to go.
          if (redirect) begin
            saved_target_d = target;
            state_d        = ST_DISCARD;
          end
        end
      end

      ST_DISCARD: begin
        if (redirect || new_inst) begin
          inst_d  = NOP_INST;
          valid_d = 1'b0;
        end
        if (redirect) begin
          saved_target_d = target;
        end
        // Wrong-path word is dropped; a redirect in the ack cycle wins.
        if (imem.ack) begin
          pc_d    = redirect ? target : saved_target_q;
          state_d = ST_FETCH;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= ST_IDLE;
      pc_q           <= RESET_PC;
      saved_target_q <= 32'd0;
      inst_q         <= NOP_INST;
      pc4_q          <= 32'd0;
      valid_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      saved_target_q <= saved_target_d;
      inst_q         <= inst_d;
      pc4_q          <= pc4_d;
      valid_q        <= valid_d;
    end
  end

  // Request depends on state only, so there is no path from ack to req.
  assign imem.req      = (state_q != ST_IDLE);
  assign imem.addr     = pc_q;
  assign if_id_inst_o  = inst_q;
  assign if_id_pc4_o   = pc4_q;
  assign if_id_valid_o = valid_q;
  assign fetch_busy_o  = ((state_q == ST_FETCH) & ~imem.ack) | (state_q == ST_DISCARD);

endmodule
